// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - execute-stage forwarding selects, load-use stall and branch flush control
module ex_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // WB producers are never forwarded (write-through register file), so only
  // the EX and MEM destination tags are tracked.
  logic              ex_v, ex_rw, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_rw;
  logic [REG_AW-1:0] mem_rd;

  logic       ex_writer, mem_writer;
  logic       stall_cond, stall, flush;
  logic       ex_take;
  logic [1:0] sel_a, sel_b;

  assign ex_writer  = ex_v  & ex_rw  & (ex_rd  != '0);
  assign mem_writer = mem_v & mem_rw & (mem_rd != '0);

  assign stall_cond = id_valid & ex_v & ex_ld & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));
  assign flush      = ex_branch_taken;
  assign stall      = stall_cond & ~flush;
  assign ex_take    = id_valid & ~(stall | flush);

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // The EX-stage writer is the youngest producer, so it is checked first.
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (ex_take && id_use_rs1) begin
      if (ex_writer && (ex_rd == id_rs1))        sel_a = 2'b10;
      else if (mem_writer && (mem_rd == id_rs1)) sel_a = 2'b01;
    end
    if (ex_take && id_use_rs2) begin
      if (ex_writer && (ex_rd == id_rs2))        sel_b = 2'b10;
      else if (mem_writer && (mem_rd == id_rs2)) sel_b = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v        <= 1'b0;
      ex_rw       <= 1'b0;
      ex_ld       <= 1'b0;
      ex_rd       <= '0;
      mem_v       <= 1'b0;
      mem_rw      <= 1'b0;
      mem_rd      <= '0;
      forwardA    <= 2'b00;
      forwardB    <= 2'b00;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      mem_v    <= ex_v;
      mem_rw   <= ex_rw;
      mem_rd   <= ex_rd;
      ex_v     <= ex_take;
      ex_rw    <= id_regwrite;
      ex_ld    <= id_memread;
      ex_rd    <= id_rd;
      forwardA <= sel_a;
      forwardB <= sel_b;
      if (stall) stall_count <= stall_count + CNT_W'(1);
      if (flush) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - randomized and directed self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken;
  logic [1:0]  forwardA, forwardB;
  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic [31:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  ex_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken),
    .forwardA(forwardA), .forwardB(forwardB),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // An issued instruction as the model sees it, with the selects it must get in EX.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic [1:0] fa;
    logic [1:0] fb;
  } instr_t;

  instr_t      in_ex, in_mem;   // instruction issued one and two cycles ago
  logic [31:0] m_stalls, m_flushes;

  function automatic logic writes(input instr_t e, input logic [4:0] r);
    return e.v && e.rw && (e.rd != 0) && (e.rd == r);
  endfunction

  function automatic logic [1:0] want_sel(input logic use_it, input logic [4:0] r);
    if (!use_it)          return 2'b00;
    if (writes(in_ex, r)) return 2'b10;
    if (writes(in_mem, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic want_stall();
    logic dep;
    dep = (id_use_rs1 && id_rs1 == in_ex.rd) || (id_use_rs2 && id_rs2 == in_ex.rd);
    return id_valid && in_ex.v && in_ex.ld && (in_ex.rd != 0) && dep && !ex_branch_taken;
  endfunction

  always @(posedge clk) begin
    instr_t nxt;
    logic   st;
    if (reset) begin
      in_ex     = '0;
      in_mem    = '0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      st     = want_stall();
      nxt.v  = id_valid && !st && !ex_branch_taken;
      nxt.rd = id_rd;
      nxt.rw = id_regwrite;
      nxt.ld = id_memread;
      nxt.fa = nxt.v ? want_sel(id_use_rs1, id_rs1) : 2'b00;
      nxt.fb = nxt.v ? want_sel(id_use_rs2, id_rs2) : 2'b00;
      if (st) m_stalls = m_stalls + 1;
      if (ex_branch_taken) m_flushes = m_flushes + 1;
      in_mem = in_ex;
      in_ex  = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic st;
    if (!reset) begin
      st = want_stall();
      chk("model_forwardA", 32'(forwardA), 32'(in_ex.fa));
      chk("model_forwardB", 32'(forwardB), 32'(in_ex.fb));
      chk("model_pc_write", 32'(pc_write), 32'(!st));
      chk("model_ifid_write", 32'(ifid_write), 32'(!st));
      chk("model_ifid_flush", 32'(ifid_flush), 32'(ex_branch_taken));
      chk("model_idex_flush", 32'(idex_flush), 32'(st || ex_branch_taken));
      chk("model_stall_count", stall_count, m_stalls);
      chk("model_flush_count", flush_count, m_flushes);
    end
  end

  // Drive one decode-stage slot just after the edge, then wait for the sampling edge.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic br);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = ld; ex_branch_taken = br;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0; ex_branch_taken = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_forwardA", 32'(forwardA), 0);
    chk("reset_forwardB", 32'(forwardB), 0);
    chk("reset_pc_write", 32'(pc_write), 1);
    chk("reset_idex_flush", 32'(idex_flush), 0);
    chk("reset_stall_count", stall_count, 0);
    chk("reset_flush_count", flush_count, 0);

    // ALU chain: add x5 ; add x6,x5,x1
    issue(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    issue(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0);
    chk("chain_no_stall", 32'(pc_write), 1);
    nop();
    chk("chain_forwardA", 32'(forwardA), 2);
    chk("chain_forwardB", 32'(forwardB), 0);
    nop(); nop();

    // Distance 2: add x7 ; nop ; sub x8,x1,x7
    issue(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
    nop();
    issue(1, 5'd1, 5'd7, 1, 1, 5'd8, 1, 0, 0);
    nop();
    chk("dist2_forwardB", 32'(forwardB), 1);
    chk("dist2_forwardA", 32'(forwardA), 0);
    nop(); nop();

    // Same with x0 as destination and source
    issue(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
    nop();
    issue(1, 5'd1, 5'd0, 1, 1, 5'd8, 1, 0, 0);
    nop();
    chk("x0_forwardB", 32'(forwardB), 0);
    nop(); nop();

    // Load-use: ld x9 ; add x10,x9,x9 (held one cycle)
    issue(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0);
    issue(1, 5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 0);
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_idex_flush", 32'(idex_flush), 1);
    issue(1, 5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 0);
    chk("lu_released", 32'(pc_write), 1);
    nop();
    chk("lu_forwardA", 32'(forwardA), 1);
    chk("lu_forwardB", 32'(forwardB), 1);
    chk("lu_stall_count", stall_count, 1);
    nop(); nop();

    // Double match: two writers of x3, youngest wins
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    issue(1, 5'd3, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    nop();
    chk("double_forwardA", 32'(forwardA), 2);
    nop(); nop();

    // Branch taken in the same cycle as a load-use condition
    issue(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 1, 0);
    issue(1, 5'd9, 5'd9, 1, 1, 5'd10, 1, 0, 1);
    chk("br_ifid_flush", 32'(ifid_flush), 1);
    chk("br_idex_flush", 32'(idex_flush), 1);
    chk("br_pc_write", 32'(pc_write), 1);
    nop();
    chk("br_forwardA", 32'(forwardA), 0);
    chk("br_forwardB", 32'(forwardB), 0);
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_count", stall_count, 1);
    nop(); nop();

    // Reset with an x4 producer in MEM
    issue(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 0);
    nop();
    @(posedge clk);
    #1 reset = 1'b1;
    id_valid = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    issue(1, 5'd4, 5'd4, 1, 1, 5'd12, 1, 0, 0);
    nop();
    chk("rst_forwardA", 32'(forwardA), 0);
    chk("rst_forwardB", 32'(forwardB), 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset           = ($urandom_range(0, 299) == 0);
      id_valid        = ($urandom_range(0, 7) != 0);
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      id_rd           = 5'($urandom_range(0, 7));
      id_regwrite     = ($urandom_range(0, 3) != 0);
      id_memread      = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
